// File: rtl/timer_pkg.sv
// ============================================================================
// Module      : timer_pkg
// Description : Shared constants and BCD helpers for the timer-set datapath
//               and the counters built on bcd_mmss_dec.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package timer_pkg;

    localparam logic [1:0] DISP_ENTRY = 2'b00;
    localparam logic [1:0] DISP_COUNT = 2'b01;
    localparam logic [1:0] DISP_ECHO  = 2'b10;
    localparam logic [1:0] DISP_BLANK = 2'b11;

    localparam logic [3:0] SS_TENS_MAX          = 4'd5;
    localparam logic [3:0] DIGIT_MAX            = 4'd9;
    localparam logic [3:0] BLANK_NIBBLE_DEFAULT = 4'hF;

    function automatic logic [3:0] clamp_nibble(input logic [3:0] v, input logic [3:0] mx);
        return (v > mx) ? mx : v;
    endfunction

    // Force an MM:SS entry into a legal countdown value.
    function automatic logic [15:0] validate_mmss(input logic [15:0] v);
        return {clamp_nibble(v[15:12], DIGIT_MAX),
                clamp_nibble(v[11:8],  DIGIT_MAX),
                clamp_nibble(v[7:4],   SS_TENS_MAX),
                clamp_nibble(v[3:0],   DIGIT_MAX)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_mmss_dec.sv
// ============================================================================
// Module      : bcd_mmss_dec
// Description : Combinational MM:SS BCD decrement with zero detect; a zero
//               input yields zero (no wrap to 99:59).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module bcd_mmss_dec
    import timer_pkg::*;
(
    input  logic [15:0] i_val,
    output logic [15:0] o_dec,
    output logic        o_zero
);

    logic [3:0] w_su;
    logic [3:0] w_st;
    logic [3:0] w_mu;
    logic [3:0] w_mt;
    logic       w_b0;
    logic       w_b1;
    logic       w_b2;

    assign o_zero = (i_val == 16'h0000);

    always_comb begin
        w_b0 = (i_val[3:0] == 4'd0);
        w_su = w_b0 ? DIGIT_MAX : (i_val[3:0] - 4'd1);

        w_b1 = w_b0 && (i_val[7:4] == 4'd0);
        w_st = !w_b0 ? i_val[7:4] :
               (w_b1 ? SS_TENS_MAX : (i_val[7:4] - 4'd1));

        w_b2 = w_b1 && (i_val[11:8] == 4'd0);
        w_mu = !w_b1 ? i_val[11:8] :
               (w_b2 ? DIGIT_MAX : (i_val[11:8] - 4'd1));

        w_mt = w_b2 ? (i_val[15:12] - 4'd1) : i_val[15:12];

        o_dec = o_zero ? 16'h0000 : {w_mt, w_mu, w_st, w_su};
    end

endmodule

`default_nettype wire

// File: rtl/timer_set_datapath.sv
// ============================================================================
// Module      : timer_set_datapath
// Description : Timer-set datapath: keypad entry buffer, BCD countdown,
//               inactivity counter and display mux. Optional auto-reload of
//               the countdown is enabled by defining TIMER_AUTORELOAD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module timer_set_datapath
    import timer_pkg::*;
#(
    parameter int          K_LAST       = 7,
    parameter logic [3:0]  BLANK_NIBBLE = BLANK_NIBBLE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sec_tick,
    input  logic [3:0]  digit_in,
    input  logic        Kc,
    input  logic        La,
    input  logic        Lb,
    input  logic        Ea,
    input  logic        Lr,
    input  logic        Er,
    input  logic [1:0]  s,
    output logic        t,
    output logic        k7,
    output logic [15:0] disp
);

    localparam logic [2:0] c_K_LAST = 3'(K_LAST);

    logic [3:0]  r_a;
    logic [3:0]  r_b;
    logic [15:0] r_e;
    logic [15:0] r_c;
    logic [2:0]  r_k;
    logic        r_t;
    logic        r_k7;
    logic [15:0] r_disp;

    logic [15:0] w_e_next;
    logic [15:0] w_c_next;
    logic [2:0]  w_k_next;
    logic [15:0] w_c_dec;
    logic        w_c_zero;
    logic [15:0] w_c_load;
    logic [15:0] w_disp_next;

`ifdef TIMER_AUTORELOAD_EN
    logic [15:0] r_s;
    logic        r_armed;
    logic        w_armed_next;
`endif

    bcd_mmss_dec u_dec (
        .i_val  (r_c),
        .o_dec  (w_c_dec),
        .o_zero (w_c_zero)
    );

    assign w_c_load = validate_mmss(r_e);

    always_comb begin
        w_e_next = r_e;
        if (Kc)
            w_e_next = 16'h0000;
        else if (Ea)
            w_e_next = {r_e[11:0], r_a};
    end

    // A clear always beats a tick landing in the same cycle.
    always_comb begin
        w_k_next = r_k;
        if (Kc || Ea)
            w_k_next = 3'd0;
        else if (sec_tick && !Er && (r_k < c_K_LAST))
            w_k_next = r_k + 3'd1;
    end

    always_comb begin
        w_c_next = r_c;
`ifdef TIMER_AUTORELOAD_EN
        w_armed_next = r_armed;
`endif
        if (Lr) begin
            w_c_next = w_c_load;
`ifdef TIMER_AUTORELOAD_EN
            w_armed_next = 1'b0;
`endif
        end else if (sec_tick && Er) begin
            if (!w_c_zero) begin
                w_c_next = w_c_dec;
`ifdef TIMER_AUTORELOAD_EN
                w_armed_next = (w_c_dec == 16'h0000);
`endif
            end
`ifdef TIMER_AUTORELOAD_EN
            else if (r_armed) begin
                w_c_next     = r_s;
                w_armed_next = 1'b0;
            end
`endif
        end
    end

    always_comb begin
        w_disp_next = {4{BLANK_NIBBLE}};
        case (s)
            DISP_ENTRY: w_disp_next = r_e;
            DISP_COUNT: w_disp_next = r_c;
            DISP_ECHO:  w_disp_next = {BLANK_NIBBLE, BLANK_NIBBLE, BLANK_NIBBLE, r_b};
            default:    w_disp_next = {4{BLANK_NIBBLE}};
        endcase
    end

    // t resets high because C resets to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= 4'd0;
            r_b    <= 4'd0;
            r_e    <= 16'h0000;
            r_c    <= 16'h0000;
            r_k    <= 3'd0;
            r_t    <= 1'b1;
            r_k7   <= 1'b0;
            r_disp <= 16'h0000;
        end else begin
            if (La)
                r_a <= clamp_nibble(digit_in, DIGIT_MAX);
            if (Lb)
                r_b <= r_a;
            r_e    <= w_e_next;
            r_c    <= w_c_next;
            r_k    <= w_k_next;
            r_t    <= (w_c_next == 16'h0000);
            r_k7   <= (w_k_next == c_K_LAST);
            r_disp <= w_disp_next;
        end
    end

`ifdef TIMER_AUTORELOAD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s     <= 16'h0000;
            r_armed <= 1'b0;
        end else begin
            if (Lr)
                r_s <= w_c_load;
            r_armed <= w_armed_next;
        end
    end
`endif

    assign t    = r_t;
    assign k7   = r_k7;
    assign disp = r_disp;

endmodule

`default_nettype wire
